sdram_pll_reset_seq: RTL and testbench

- Sits directly downstream of the SDRAM system PLL wrapper and is clocked by its 50 MHz outclk_0.
- Consumes the PLL's asynchronous locked output and filters it.
- Enforces the SDRAM power-up delay, then releases the system reset and runs a request/acknowledge handshake that starts SDRAM controller initialisation.
- On loss of lock or an init timeout, it re-asserts system reset and drives a timed reset pulse back into the PLL's rst input.

---
 rtl/sdram_pll_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 23 ++
 rtl/sdram_pll_reset_seq.sv | 155 +++++++++++++++
 tb/tb_sdram_pll_reset_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pll_pkg.sv
// Shared types and defaults for the SDRAM PLL reset sequencer: FSM state
// encoding, fault cause codes and the 50 MHz default timing constants.
package sdram_pll_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_FILTER    = 3'd1,
    ST_PWRUP     = 3'd2,
    ST_INIT      = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE         = 2'd0,
    CAUSE_LOCK_LOST    = 2'd1,
    CAUSE_INIT_TIMEOUT = 2'd2
  } cause_e;

  localparam int PWRUP_CYCLES_50MHZ = 10000;
  localparam int LOCK_FILTER_DEF    = 1024;
  localparam int INIT_TIMEOUT_DEF   = 65535;
  localparam int PLL_RST_CYCLES_DEF = 16;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser, asynchronous active-high reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs before either updates; blocking here would collapse the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_pll_reset_seq.sv
// Filters PLL lock, enforces the SDRAM power-up wait, handshakes controller
// init and pulses the PLL reset on faults. SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN adds fault status.
module sdram_pll_reset_seq
  import sdram_pll_pkg::*;
#(
  parameter int LOCK_FILTER    = LOCK_FILTER_DEF,
  parameter int PWRUP_CYCLES   = PWRUP_CYCLES_50MHZ,
  parameter int INIT_TIMEOUT   = INIT_TIMEOUT_DEF,
  parameter int PLL_RST_CYCLES = PLL_RST_CYCLES_DEF,
  parameter int CNT_W          = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst_req,
  output logic       sys_rst,
  output logic       init_req,
  input  logic       init_ack,
  output logic       ready,
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
  output logic [7:0] fault_cnt,
  output logic [1:0] last_cause,
`endif
  output logic [2:0] state_o
);

  localparam longint CNT_NEED = longint'(max4(LOCK_FILTER, PWRUP_CYCLES, INIT_TIMEOUT, PLL_RST_CYCLES));

  if (CNT_NEED > (longint'(1) << CNT_W) - 1) begin : g_cnt_w_too_small
    $error("sdram_pll_reset_seq: CNT_W too narrow for the configured delays");
  end

  localparam logic [CNT_W-1:0] LOAD_FILTER = CNT_W'(LOCK_FILTER - 1);
  localparam logic [CNT_W-1:0] LOAD_PWRUP  = CNT_W'(PWRUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOAD_INIT   = CNT_W'(INIT_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOAD_RST    = CNT_W'(PLL_RST_CYCLES - 1);

  logic             lk_s;
  state_e           state;
  logic [CNT_W-1:0] cnt;
  cause_e           fault_cause;
  logic             fault_entry;

  sync_2ff u_lock_sync (
    .clk (clk),
    .rst (rst),
    .d   (pll_locked),
    .q   (lk_s)
  );

  // Lock loss outranks init_ack; init_ack outranks the timeout.
  always_comb begin
    fault_cause = CAUSE_NONE;
    case (state)
      ST_PWRUP, ST_RUN: if (!lk_s) fault_cause = CAUSE_LOCK_LOST;
      ST_INIT: begin
        if (!lk_s)                         fault_cause = CAUSE_LOCK_LOST;
        else if (!init_ack && cnt == '0)   fault_cause = CAUSE_INIT_TIMEOUT;
      end
      default: ;
    endcase
  end

  assign fault_entry = (fault_cause != CAUSE_NONE);
  assign state_o     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_WAIT_LOCK;
      cnt         <= '0;
      pll_rst_req <= 1'b0;
      sys_rst     <= 1'b1;
      init_req    <= 1'b0;
      ready       <= 1'b0;
    end else if (fault_entry) begin
      state       <= ST_FAULT;
      cnt         <= LOAD_RST;
      pll_rst_req <= 1'b1;
      sys_rst     <= 1'b1;
      init_req    <= 1'b0;
      ready       <= 1'b0;
    end else begin
      case (state)
        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state <= ST_FILTER;
            cnt   <= LOAD_FILTER;
          end
        end
        ST_FILTER: begin
          if (!lk_s) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == '0) begin
            state <= ST_PWRUP;
            cnt   <= LOAD_PWRUP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_PWRUP: begin
          if (cnt == '0) begin
            state    <= ST_INIT;
            cnt      <= LOAD_INIT;
            sys_rst  <= 1'b0;
            init_req <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_INIT: begin
          // A zero count without init_ack was already diverted to FAULT above.
          if (init_ack) begin
            state    <= ST_RUN;
            cnt      <= '0;
            init_req <= 1'b0;
            ready    <= 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_RUN: ;
        ST_FAULT: begin
          if (cnt == '0) begin
            state       <= ST_WAIT_LOCK;
            pll_rst_req <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          state       <= ST_WAIT_LOCK;
          cnt         <= '0;
          pll_rst_req <= 1'b0;
          sys_rst     <= 1'b1;
          init_req    <= 1'b0;
          ready       <= 1'b0;
        end
      endcase
    end
  end

`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_cnt  <= '0;
      last_cause <= CAUSE_NONE;
    end else if (fault_entry) begin
      if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 1'b1;
      last_cause <= fault_cause;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_pll_reset_seq.sv
// Directed self-checking bench for sdram_pll_reset_seq using the reduced
// timing set LOCK_FILTER=8, PWRUP_CYCLES=20, INIT_TIMEOUT=30, PLL_RST_CYCLES=4.
module tb_sdram_pll_reset_seq;

  localparam int LF = 8;
  localparam int PW = 20;
  localparam int TO = 30;
  localparam int PR = 4;
  // Edges from the first edge that samples pll_locked=1 (counted as 1) to the
  // edge that drops sys_rst: 1 + 2 sync + 8 filter + 20 power-up.
  localparam int BRINGUP_EDGES = 1 + 2 + LF + PW;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst_req;
  logic       sys_rst;
  logic       init_req;
  logic       init_ack;
  logic       ready;
  logic [2:0] state_o;
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
  logic [7:0] fault_cnt;
  logic [1:0] last_cause;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  sdram_pll_reset_seq #(
    .LOCK_FILTER    (LF),
    .PWRUP_CYCLES   (PW),
    .INIT_TIMEOUT   (TO),
    .PLL_RST_CYCLES (PR),
    .CNT_W          (17)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pll_locked  (pll_locked),
    .pll_rst_req (pll_rst_req),
    .sys_rst     (sys_rst),
    .init_req    (init_req),
    .init_ack    (init_ack),
    .ready       (ready),
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
    .fault_cnt   (fault_cnt),
    .last_cause  (last_cause),
`endif
    .state_o     (state_o)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reset_dut();
    rst        = 1'b1;
    pll_locked = 1'b0;
    init_ack   = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(3);
  endtask

  // Steps until sys_rst drops (bounded); flags any FAULT activity on the way.
  task automatic run_to_init(output int cycles, output logic saw_fault);
    cycles    = 0;
    saw_fault = 1'b0;
    while (sys_rst !== 1'b0 && cycles < 200) begin
      tick();
      cycles++;
      if (pll_rst_req === 1'b1 || state_o === 3'd5) saw_fault = 1'b1;
    end
  endtask

  task automatic measure_pulse(output int width);
    width = 0;
    while (pll_rst_req === 1'b1 && width < 50) begin
      width++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    pll_locked = 1'b0;
    init_ack   = 1'b0;
    tick(2);
    n_total++; if (state_o !== 3'd0) $display("FAIL reset_state: state_o=%0d expected 0", state_o); else n_pass++;
    n_total++; if (sys_rst !== 1'b1) $display("FAIL reset_sys_rst: sys_rst=%b expected 1", sys_rst); else n_pass++;
    n_total++; if (pll_rst_req !== 1'b0) $display("FAIL reset_pll_rst_req: pll_rst_req=%b expected 0", pll_rst_req); else n_pass++;
    n_total++; if (init_req !== 1'b0) $display("FAIL reset_init_req: init_req=%b expected 0", init_req); else n_pass++;
    n_total++; if (ready !== 1'b0) $display("FAIL reset_ready: ready=%b expected 0", ready); else n_pass++;
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
    n_total++; if (fault_cnt !== 8'd0) $display("FAIL reset_fault_cnt: fault_cnt=%0d expected 0", fault_cnt); else n_pass++;
`endif
    rst = 1'b0;
    tick(3);
    n_total++; if (state_o !== 3'd0) $display("FAIL idle_no_lock: state_o=%0d expected 0", state_o); else n_pass++;
  endtask

  task automatic test_clean_bringup();
    int   c;
    logic f;
    reset_dut();
    pll_locked = 1'b1;
    run_to_init(c, f);
    n_total++; if (c !== BRINGUP_EDGES) $display("FAIL bringup_latency: edges=%0d expected %0d", c, BRINGUP_EDGES); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL bringup_no_fault: saw_fault=%b expected 0", f); else n_pass++;
    n_total++; if (state_o !== 3'd3 || init_req !== 1'b1) $display("FAIL bringup_init: state_o=%0d init_req=%b expected 3/1", state_o, init_req); else n_pass++;
    tick(4);
    n_total++; if (state_o !== 3'd3 || ready !== 1'b0) $display("FAIL bringup_waiting: state_o=%0d ready=%b expected 3/0", state_o, ready); else n_pass++;
    init_ack = 1'b1;
    tick();
    init_ack = 1'b0;
    n_total++; if (ready !== 1'b1) $display("FAIL bringup_ready: ready=%b expected 1", ready); else n_pass++;
    n_total++; if (state_o !== 3'd4) $display("FAIL bringup_run_state: state_o=%0d expected 4", state_o); else n_pass++;
    n_total++; if (init_req !== 1'b0 || sys_rst !== 1'b0) $display("FAIL bringup_run_outs: init_req=%b sys_rst=%b expected 0/0", init_req, sys_rst); else n_pass++;
    tick(3);
    n_total++; if (state_o !== 3'd4 || ready !== 1'b1) $display("FAIL run_stable: state_o=%0d ready=%b expected 4/1", state_o, ready); else n_pass++;
  endtask

  task automatic test_glitchy_lock();
    int   c;
    logic f;
    reset_dut();
    pll_locked = 1'b1;
    tick(5);
    n_total++; if (state_o !== 3'd1) $display("FAIL glitch_filtering: state_o=%0d expected 1", state_o); else n_pass++;
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    tick(2);
    n_total++; if (state_o !== 3'd0 || pll_rst_req !== 1'b0) $display("FAIL glitch_restart: state_o=%0d pll_rst_req=%b expected 0/0", state_o, pll_rst_req); else n_pass++;
    run_to_init(c, f);
    // The re-rise was sampled two edges before the restart check above.
    n_total++; if (c !== BRINGUP_EDGES - 2) $display("FAIL glitch_full_filter: edges=%0d expected %0d", c, BRINGUP_EDGES - 2); else n_pass++;
    n_total++; if (f !== 1'b0) $display("FAIL glitch_no_fault: saw_fault=%b expected 0", f); else n_pass++;
  endtask

  task automatic test_init_timeout();
    int   c;
    int   w;
    logic f;
    reset_dut();
    pll_locked = 1'b1;
    run_to_init(c, f);
    w = 0;
    while (init_req === 1'b1 && w < 100) begin
      w++;
      tick();
    end
    n_total++; if (w !== TO) $display("FAIL timeout_init_req_len: cycles=%0d expected %0d", w, TO); else n_pass++;
    n_total++; if (state_o !== 3'd5 || sys_rst !== 1'b1 || ready !== 1'b0) $display("FAIL timeout_fault: state_o=%0d sys_rst=%b ready=%b expected 5/1/0", state_o, sys_rst, ready); else n_pass++;
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
    n_total++; if (fault_cnt !== 8'd1) $display("FAIL timeout_fault_cnt: fault_cnt=%0d expected 1", fault_cnt); else n_pass++;
    n_total++; if (last_cause !== 2'd2) $display("FAIL timeout_cause: last_cause=%0d expected 2", last_cause); else n_pass++;
`endif
    measure_pulse(w);
    n_total++; if (w !== PR) $display("FAIL timeout_pulse_width: width=%0d expected %0d", w, PR); else n_pass++;
    n_total++; if (state_o !== 3'd0) $display("FAIL timeout_back_to_wait: state_o=%0d expected 0", state_o); else n_pass++;
  endtask

  task automatic test_lock_loss_run();
    int   c;
    int   w;
    logic f;
    reset_dut();
    pll_locked = 1'b1;
    run_to_init(c, f);
    init_ack = 1'b1;
    tick();
    init_ack   = 1'b0;
    pll_locked = 1'b0;
    tick(2);
    n_total++; if (ready !== 1'b1) $display("FAIL lockloss_sync_delay: ready=%b expected 1", ready); else n_pass++;
    tick();
    n_total++; if (sys_rst !== 1'b1 || ready !== 1'b0) $display("FAIL lockloss_outs: sys_rst=%b ready=%b expected 1/0", sys_rst, ready); else n_pass++;
    n_total++; if (state_o !== 3'd5) $display("FAIL lockloss_state: state_o=%0d expected 5", state_o); else n_pass++;
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
    n_total++; if (last_cause !== 2'd1) $display("FAIL lockloss_cause: last_cause=%0d expected 1", last_cause); else n_pass++;
`endif
    measure_pulse(w);
    n_total++; if (w !== PR) $display("FAIL lockloss_pulse_width: width=%0d expected %0d", w, PR); else n_pass++;
    tick(2);
    n_total++; if (state_o !== 3'd0) $display("FAIL lockloss_wait: state_o=%0d expected 0", state_o); else n_pass++;
    pll_locked = 1'b1;
    run_to_init(c, f);
    n_total++; if (c !== BRINGUP_EDGES) $display("FAIL relock_latency: edges=%0d expected %0d", c, BRINGUP_EDGES); else n_pass++;
    init_ack = 1'b1;
    tick();
    init_ack = 1'b0;
    n_total++; if (state_o !== 3'd4) $display("FAIL relock_run: state_o=%0d expected 4", state_o); else n_pass++;
  endtask

  task automatic test_simultaneous();
    int   c;
    logic f;
    reset_dut();
    pll_locked = 1'b1;
    run_to_init(c, f);
    tick(TO - 1);
    n_total++; if (state_o !== 3'd3) $display("FAIL simul_pre_timeout: state_o=%0d expected 3", state_o); else n_pass++;
    init_ack = 1'b1;
    tick();
    init_ack = 1'b0;
    n_total++; if (state_o !== 3'd4 || ready !== 1'b1) $display("FAIL simul_ack_beats_timeout: state_o=%0d ready=%b expected 4/1", state_o, ready); else n_pass++;

    reset_dut();
    pll_locked = 1'b1;
    run_to_init(c, f);
    pll_locked = 1'b0;
    tick(2);
    n_total++; if (state_o !== 3'd3) $display("FAIL simul_pre_lockloss: state_o=%0d expected 3", state_o); else n_pass++;
    init_ack = 1'b1;
    tick();
    init_ack = 1'b0;
    n_total++; if (state_o !== 3'd5 || pll_rst_req !== 1'b1) $display("FAIL simul_lockloss_beats_ack: state_o=%0d pll_rst_req=%b expected 5/1", state_o, pll_rst_req); else n_pass++;
  endtask

  // Entered while the previous scenario left the DUT at the start of a FAULT pulse.
  task automatic test_rst_in_fault();
    tick();
    n_total++; if (pll_rst_req !== 1'b1) $display("FAIL rstfault_pulse_active: pll_rst_req=%b expected 1", pll_rst_req); else n_pass++;
    rst = 1'b1;
    #2;
    n_total++; if (pll_rst_req !== 1'b0 || sys_rst !== 1'b1) $display("FAIL rstfault_async: pll_rst_req=%b sys_rst=%b expected 0/1", pll_rst_req, sys_rst); else n_pass++;
    n_total++; if (state_o !== 3'd0) $display("FAIL rstfault_state: state_o=%0d expected 0", state_o); else n_pass++;
`ifdef SDRAM_PLL_RESET_SEQ_FAULT_CNT_EN
    n_total++; if (fault_cnt !== 8'd0) $display("FAIL rstfault_fault_cnt: fault_cnt=%0d expected 0", fault_cnt); else n_pass++;
`endif
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_glitchy_lock();
    test_init_timeout();
    test_lock_loss_run();
    test_simultaneous();
    test_rst_in_fault();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
